rom_download_packer: RTL and testbench

- Sits between the HPS ioctl download stream and the SDRAM controller port used while ROMs are loading.
- Packs byte-wide ioctl writes into 32-bit little-endian words and buffers them in a small FIFO.
- Issues SDRAM write requests with a req/ack handshake and throttles the HPS through ioctl_wait.
- Signals completion once the download has ended and every word has been written.

---
 rtl/tecmo_dl_pkg.sv | 7 +
 rtl/rom_download_packer_sync_fifo.sv | 42 ++++
 rtl/rom_download_packer.sv | 118 +++++++++++
 tb/tb_rom_download_packer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tecmo_dl_pkg.sv
// tecmo_dl_pkg: shared types for the ROM download packer
package tecmo_dl_pkg;
  typedef enum logic {IDLE, REQ} state_t;
  typedef logic [31:0] word_t;
  typedef logic [17:0] waddr_t;
  localparam int LANE_BYTES = 4;
endpackage

// File: rtl/rom_download_packer_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; push when full is dropped unless a pop frees a slot
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  always_comb begin
    full = count == CW'(DEPTH);
    empty = count == '0;
    do_push = push & (~full | pop);
    do_pop = pop & ~empty;
    dout = mem[rp];
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/rom_download_packer.sv
// rom_download_packer: packs ioctl download bytes into 32-bit words and writes them to SDRAM via req/ack
module rom_download_packer
  import tecmo_dl_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [22:0] BASE_ADDR  = 23'h000000,
  parameter int          WAIT_LEVEL = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  input  logic        ioctl_download,
  output logic        ioctl_wait,
  output logic [22:0] sdram_addr,
  output logic [31:0] sdram_data,
  output logic        sdram_we,
  output logic        sdram_req,
  input  logic        sdram_ack,
  output logic        done,
  output logic        overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  word_t acc_data, lane_word, merged;
  logic [LANE_BYTES-1:0] acc_mask, lane_bit;
  waddr_t acc_addr, waddr;
  logic [1:0] lane;
  logic pend, dl_q, armed, strobe, mismatch, last_lane, fall, take_new, push, pop, fire, full, empty;
  logic [49:0] push_word, head;
  logic [CW-1:0] count;
  state_t state;
  always_comb begin
    lane = ioctl_addr[1:0];
    waddr = ioctl_addr[19:2];
    strobe = ioctl_wr & ioctl_download;
    mismatch = (|acc_mask) & (waddr != acc_addr);
    last_lane = lane == 2'd3;
    fall = dl_q & ~ioctl_download;
    lane_word = word_t'(ioctl_data) << {lane, 3'b000};
    lane_bit = LANE_BYTES'(1) << lane;
    merged = (mismatch ? '0 : acc_data) | lane_word;
    take_new = strobe & ~mismatch & last_lane;
    push = (strobe & (mismatch | last_lane)) | pend | (fall & (|acc_mask));
    push_word = take_new ? {waddr, merged} : {acc_addr, acc_data};
    pop = (state == REQ) & sdram_ack & ~reset;
    fire = armed & empty & (state == IDLE) & ~pend & ~push;
  end
  // pend marks a lane-3 byte that arrived on a mismatch; its word goes out one cycle after the partial
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_data <= '0;
      acc_mask <= '0;
      acc_addr <= '0;
      pend <= 1'b0;
    end else begin
      pend <= strobe & mismatch & last_lane;
      if (strobe & mismatch) begin
        acc_data <= lane_word;
        acc_mask <= lane_bit;
        acc_addr <= waddr;
      end else if (take_new | pend | fall) begin
        acc_data <= '0;
        acc_mask <= '0;
        acc_addr <= '0;
      end else if (strobe) begin
        acc_data <= merged;
        acc_mask <= acc_mask | lane_bit;
        acc_addr <= waddr;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_q <= 1'b0;
      armed <= 1'b0;
      done <= 1'b0;
      ioctl_wait <= 1'b0;
      overflow <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      armed <= fall | (armed & ~fire & ~(ioctl_download & ~dl_q));
      done <= fire;
      ioctl_wait <= (32'(count) >= WAIT_LEVEL) | pend;
      overflow <= overflow | (push & full & ~pop);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sdram_addr <= '0;
      sdram_data <= '0;
      sdram_req <= 1'b0;
      sdram_we <= 1'b0;
    end else if (state == IDLE && !empty) begin
      sdram_addr <= BASE_ADDR + {5'b0, head[49:32]};
      sdram_data <= head[31:0];
      sdram_req <= 1'b1;
      sdram_we <= 1'b1;
      state <= REQ;
    end else if (state == REQ && sdram_ack) begin
      sdram_req <= 1'b0;
      sdram_we <= 1'b0;
      state <= IDLE;
    end
  end
  sync_fifo #(.WIDTH(50), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(push_word),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_rom_download_packer.sv
// tb_rom_download_packer: directed vector table plus hand-written sequences for the download packer
module tb_rom_download_packer;
  logic clk = 1'b0, reset = 1'b1;
  logic [19:0] ioctl_addr = '0;
  logic [7:0] ioctl_data = '0;
  logic ioctl_wr = 1'b0, ioctl_download = 1'b0, sdram_ack = 1'b0;
  logic wait_a, we_a, req_a, done_a, ovf_a, wait_b, we_b, req_b, done_b, ovf_b;
  logic [22:0] addr_a, addr_b;
  logic [31:0] data_a, data_b;
  typedef struct {logic [22:0] a; logic [31:0] d; logic [22:0] b;} wr_t;
  typedef struct {logic [19:0] addr; logic [31:0] bytes; logic [3:0] lanes; logic [22:0] ea; logic [31:0] ed; logic [22:0] eb;} vec_t;
  wr_t log_q[$];
  int gaps[$];
  vec_t vecs[6];
  int total = 0, bad = 0, cyc = 0, done_cnt = 0, req_rise = -1, ack_delay = 3, wcnt = 0, low_len = 0;
  int last_strobe = 0, n0 = 0, d0 = 0, t0 = 0, t = 0;
  bit ack_hold = 1'b0;
  logic req_prev = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  rom_download_packer u_a (
    .clk(clk), .reset(reset), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .ioctl_download(ioctl_download), .ioctl_wait(wait_a), .sdram_addr(addr_a), .sdram_data(data_a),
    .sdram_we(we_a), .sdram_req(req_a), .sdram_ack(sdram_ack), .done(done_a), .overflow(ovf_a)
  );
  rom_download_packer #(.BASE_ADDR(23'h100000)) u_b (
    .clk(clk), .reset(reset), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .ioctl_download(ioctl_download), .ioctl_wait(wait_b), .sdram_addr(addr_b), .sdram_data(data_b),
    .sdram_we(we_b), .sdram_req(req_b), .sdram_ack(sdram_ack), .done(done_b), .overflow(ovf_b)
  );
  // SDRAM controller stand-in: acks after ack_delay cycles unless held, and logs each accepted write
  initial forever begin
    @(negedge clk);
    if (done_a) done_cnt++;
    if (req_a && !req_prev) begin
      req_rise = cyc;
      gaps.push_back(low_len);
    end
    low_len = req_a ? 0 : low_len + 1;
    req_prev = req_a;
    if (reset) begin
      sdram_ack = 1'b0;
      wcnt = 0;
    end else if (sdram_ack) sdram_ack = 1'b0;
    else if (req_a && !ack_hold) begin
      if (wcnt >= ack_delay) begin
        sdram_ack = 1'b1;
        wcnt = 0;
        log_q.push_back('{addr_a, data_a, addr_b});
      end else wcnt++;
    end
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr_byte(input logic [19:0] a, input logic [7:0] d);
    @(negedge clk);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr = 1'b1;
    last_strobe = cyc;
    @(negedge clk);
    ioctl_wr = 1'b0;
    @(negedge clk);
  endtask
  task automatic wait_writes(input int n, input string name);
    t = 0;
    while (log_q.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(name, 64'(log_q.size()), 64'(n));
  endtask
  task automatic set_dl(input logic v);
    @(negedge clk);
    ioctl_download = v;
  endtask
  initial begin
    vecs[0] = '{20'h00000, 32'h44332211, 4'hF, 23'h000000, 32'h44332211, 23'h100000};
    vecs[1] = '{20'h0FFFC, 32'hDDCCBBAA, 4'hF, 23'h003FFF, 32'hDDCCBBAA, 23'h103FFF};
    vecs[2] = '{20'hFFFFC, 32'h01020304, 4'hF, 23'h03FFFF, 32'h01020304, 23'h13FFFF};
    vecs[3] = '{20'h00010, 32'h12773455, 4'b0101, 23'h000004, 32'h00770055, 23'h100004};
    vecs[4] = '{20'h00024, 32'h99887766, 4'b1000, 23'h000009, 32'h99000000, 23'h100009};
    vecs[5] = '{20'h00008, 32'h000000CC, 4'b0001, 23'h000002, 32'h000000CC, 23'h100002};
    idle(3);
    check("rst_req", 64'(req_a), 0);
    check("rst_we", 64'(we_a), 0);
    check("rst_wait", 64'(wait_a), 0);
    check("rst_done", 64'(done_a), 0);
    check("rst_ovf", 64'(ovf_a), 0);
    check("rst_addr_data", {9'b0, addr_a, data_a}, 0);
    reset = 1'b0;
    idle(2);
    for (int i = 0; i < 6; i++) begin
      n0 = log_q.size();
      d0 = done_cnt;
      req_rise = -1;
      set_dl(1'b1);
      for (int l = 0; l < 4; l++)
        if (vecs[i].lanes[l]) wr_byte(vecs[i].addr | 20'(l), vecs[i].bytes[8*l +: 8]);
      idle(2);
      if (vecs[i].lanes[3]) check($sformatf("v%0d_latency", i), 64'(req_rise - last_strobe), 2);
      set_dl(1'b0);
      wait_writes(n0 + 1, $sformatf("v%0d_count", i));
      if (log_q.size() > n0) begin
        check($sformatf("v%0d_addr", i), 64'(log_q[n0].a), 64'(vecs[i].ea));
        check($sformatf("v%0d_data", i), 64'(log_q[n0].d), 64'(vecs[i].ed));
        check($sformatf("v%0d_addr_base", i), 64'(log_q[n0].b), 64'(vecs[i].eb));
      end
      t = 0;
      while (done_cnt == d0 && t < 50) begin
        @(negedge clk);
        t++;
      end
      idle(3);
      check($sformatf("v%0d_done", i), 64'(done_cnt - d0), 1);
    end
    // partial word pushed on address change, remainder flushed at download end
    n0 = log_q.size();
    set_dl(1'b1);
    wr_byte(20'h00000, 8'hAA);
    wr_byte(20'h00001, 8'hBB);
    wr_byte(20'h00008, 8'hCC);
    idle(10);
    check("mis_before_end", 64'(log_q.size() - n0), 1);
    set_dl(1'b0);
    wait_writes(n0 + 2, "mis_count");
    if (log_q.size() >= n0 + 2) begin
      check("mis_w0", {log_q[n0].a, log_q[n0].d}, {23'h0, 32'h0000BBAA});
      check("mis_w1", {log_q[n0+1].a, log_q[n0+1].d}, {23'h2, 32'h000000CC});
    end
    // mismatch where the new byte completes its own word
    n0 = log_q.size();
    set_dl(1'b1);
    wr_byte(20'h00000, 8'h11);
    wr_byte(20'h00007, 8'h77);
    wait_writes(n0 + 2, "mis3_count");
    if (log_q.size() >= n0 + 2) begin
      check("mis3_w0", {log_q[n0].a, log_q[n0].d}, {23'h0, 32'h00000011});
      check("mis3_w1", {log_q[n0+1].a, log_q[n0+1].d}, {23'h1, 32'h77000000});
    end
    set_dl(1'b0);
    idle(10);
    // back-pressure: ack withheld while four words are streamed
    n0 = log_q.size();
    ack_hold = 1'b1;
    set_dl(1'b1);
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      wr_byte(20'(i), 8'(8'h10 + i));
      if (i == 7) begin
        idle(1);
        check("wait_cnt2", 64'(wait_a), 0);
      end
      if (i == 11) begin
        idle(1);
        check("wait_cnt3", 64'(wait_a), 1);
      end
    end
    idle(2);
    check("bp_no_ovf", 64'(ovf_a), 0);
    check("bp_wait_full", 64'(wait_a), 1);
    set_dl(1'b0);
    while (cyc - t0 < 200) @(negedge clk);
    check("bp_held", 64'(log_q.size()), 64'(n0));
    gaps.delete();
    ack_delay = 0;
    ack_hold = 1'b0;
    wait_writes(n0 + 4, "bp_count");
    if (log_q.size() >= n0 + 4)
      for (int k = 0; k < 4; k++)
        check($sformatf("bp_w%0d", k), {log_q[n0+k].a, log_q[n0+k].d},
              {23'(k), 8'(19 + 4*k), 8'(18 + 4*k), 8'(17 + 4*k), 8'(16 + 4*k)});
    idle(5);
    check("bp_gap_n", 64'(gaps.size()), 3);
    foreach (gaps[g]) check($sformatf("bp_gap%0d", g), 64'(gaps[g]), 1);
    check("bp_wait_clr", 64'(wait_a), 0);
    // overflow: five words with ack held against a four-deep FIFO
    n0 = log_q.size();
    ack_hold = 1'b1;
    set_dl(1'b1);
    for (int i = 0; i < 20; i++) wr_byte(20'(i), 8'(8'h40 + i));
    idle(2);
    check("ovf_set", 64'(ovf_a), 1);
    set_dl(1'b0);
    ack_hold = 1'b0;
    idle(150);
    check("ovf_count", 64'(log_q.size() - n0), 4);
    if (log_q.size() >= n0 + 4) begin
      check("ovf_first", {log_q[n0].a, log_q[n0].d}, {23'h0, 32'h43424140});
      check("ovf_last", {log_q[n0+3].a, log_q[n0+3].d}, {23'h3, 32'h4F4E4D4C});
    end
    check("ovf_sticky", 64'(ovf_a), 1);
    // reset while a request is outstanding
    n0 = log_q.size();
    ack_hold = 1'b1;
    set_dl(1'b1);
    for (int i = 0; i < 4; i++) wr_byte(20'h40 + 20'(i), 8'(8'h60 + i));
    t = 0;
    while (!req_a && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rr_req_before", 64'(req_a), 1);
    @(negedge clk);
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clk);
    check("rr_req_drop", 64'(req_a), 0);
    check("rr_ovf_clr", 64'(ovf_a), 0);
    reset = 1'b0;
    ack_hold = 1'b0;
    idle(20);
    check("rr_fifo_empty", 64'(log_q.size()), 64'(n0));
    set_dl(1'b1);
    wr_byte(20'h00044, 8'h5A);
    wr_byte(20'h00045, 8'hA5);
    wr_byte(20'h00046, 8'h3C);
    wr_byte(20'h00047, 8'hC3);
    wait_writes(n0 + 1, "rr_after_count");
    if (log_q.size() > n0) check("rr_after_w", {log_q[n0].a, log_q[n0].d}, {23'h11, 32'hC33CA55A});
    set_dl(1'b0);
    idle(5);
    wr_byte(20'h0007F, 8'hEE);
    idle(20);
    check("wr_no_download", 64'(log_q.size()), 64'(n0 + 1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
